// File: rtl/sprite_ram_write_arbiter.sv
// sprite_ram_write_arbiter: round-robin burst arbiter feeding the sprite pixel RAM write port
module sprite_ram_write_arbiter #(
    parameter int ADD_WIDTH     = 16,
    parameter int NR_OF_MASTERS = 4,
    parameter int MAX_BURST     = 16,
    parameter int IDLE_TIMEOUT  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_allow,
    input  logic [NR_OF_MASTERS-1:0]         m_valid,
    input  logic [ADD_WIDTH-1:0]             m_add [NR_OF_MASTERS],
    input  logic [11:0]                      m_data [NR_OF_MASTERS],
    input  logic [NR_OF_MASTERS-1:0]         m_last,
    output logic [NR_OF_MASTERS-1:0]         m_ready,
    output logic [ADD_WIDTH-1:0]             wr_add,
    output logic [11:0]                      wr_data,
    output logic                             wr_req,
    output logic [$clog2(NR_OF_MASTERS)-1:0] grant_id,
    output logic                             busy
);
    localparam int GW = $clog2(NR_OF_MASTERS);
    localparam int CW = $clog2(MAX_BURST);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d, rr_q, rr_d, pick, idx;
    logic [CW-1:0]          beat_q, beat_d;
    logic [TW-1:0]          idle_q, idle_d;
    logic                   wr_req_q, wr_req_d;
    logic [ADD_WIDTH-1:0]   wr_add_q, wr_add_d;
    logic [11:0]            wr_data_q, wr_data_d;
    logic                   accept, done, timeout;

    assign busy     = state_q == BURST;
    assign grant_id = grant_q;
    assign wr_req   = wr_req_q;
    assign wr_add   = wr_add_q;
    assign wr_data  = wr_data_q;
    assign accept   = busy && wr_allow && m_valid[grant_q];
    assign done     = accept && (m_last[grant_q] || beat_q == CW'(MAX_BURST - 1));
    assign timeout  = busy && wr_allow && !m_valid[grant_q] && idle_q == TW'(IDLE_TIMEOUT - 1);

    for (genvar i = 0; i < NR_OF_MASTERS; i++) begin : g_ready
        assign m_ready[i] = busy && wr_allow && grant_q == GW'(i);
    end

    // Round-robin search: scanning offsets downward lets the smallest offset from rr_q win
    always_comb begin
        pick = rr_q;
        idx  = rr_q;
        for (int k = NR_OF_MASTERS - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % NR_OF_MASTERS);
            if (m_valid[idx]) pick = idx;
        end
    end

    // Next-state: grant in IDLE, count beats / idle cycles in BURST, stall while wr_allow is low
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        wr_req_d  = accept;
        wr_add_d  = accept ? m_add[grant_q] : wr_add_q;
        wr_data_d = accept ? m_data[grant_q] : wr_data_q;
        if (!busy) begin
            if (wr_allow && |m_valid) begin
                state_d = BURST;
                grant_d = pick;
                beat_d  = '0;
                idle_d  = '0;
            end
        end else if (wr_allow) begin
            beat_d = accept ? beat_q + 1'b1 : beat_q;
            idle_d = accept ? '0 : idle_q + 1'b1;
            if (done || timeout) begin
                state_d = IDLE;
                rr_d    = grant_q == GW'(NR_OF_MASTERS - 1) ? '0 : grant_q + 1'b1;
            end
        end
    end

    // State and output registers; reset drops any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            idle_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_add_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            idle_q    <= idle_d;
            wr_req_q  <= wr_req_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_sprite_ram_write_arbiter.sv
// tb_sprite_ram_write_arbiter: scoreboard plus vector-table bench for the sprite RAM write arbiter
module tb_sprite_ram_write_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;

    typedef struct packed {logic [AW-1:0] a; logic [11:0] d;} wr_t;
    typedef struct packed {logic [AW-1:0] a; logic [11:0] d; logic l;} beat_t;
    typedef struct packed {
        logic       wa;
        logic [3:0] v;
        logic [3:0] l;
        logic       b;
        logic [1:0] g;
        logic [3:0] r;
        logic       w;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wr_allow = 1'b0;
    logic [N-1:0]   m_valid = '0, m_last = '0, m_ready;
    logic [AW-1:0]  m_add [N];
    logic [11:0]    m_data [N];
    logic [AW-1:0]  wr_add;
    logic [11:0]    wr_data;
    logic           wr_req;
    logic [1:0]     grant_id;
    logic           busy;

    wr_t            sb[$];
    beat_t          mq[N][$];
    int             glog[$];
    int             gbeats[$];
    logic [N-1:0]   hold = '0;
    logic [N-1:0]   acc;
    logic           busy_p = 1'b0;
    int             npass = 0;
    int             ntot = 0;
    vec_t           tbl[13];

    sprite_ram_write_arbiter #(
        .ADD_WIDTH(AW), .NR_OF_MASTERS(N), .MAX_BURST(16), .IDLE_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .wr_allow(wr_allow), .m_valid(m_valid), .m_add(m_add),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .wr_add(wr_add),
        .wr_data(wr_data), .wr_req(wr_req), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", n, got, exp);
        else npass++;
    endtask

    function automatic int pending();
        int s = sb.size();
        for (int i = 0; i < N; i++) s += mq[i].size();
        return s;
    endfunction

    task automatic load(input int i, input logic [AW-1:0] a0, input logic [11:0] d0,
                        input int dstep, input int n, input int lst);
        for (int k = 0; k < n; k++)
            mq[i].push_back({a0 + AW'(k), d0 + 12'(k * dstep), lst == 2 || (lst == 1 && k == n - 1)});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0 && !hold[i]) begin
                m_valid[i] = 1'b1;
                m_add[i]   = mq[i][0].a;
                m_data[i]  = mq[i][0].d;
                m_last[i]  = mq[i][0].l;
            end else begin
                m_valid[i] = 1'b0;
                m_last[i]  = 1'b0;
            end
        end
    endtask

    // Check write port against scoreboard, then record beats accepted this cycle
    task automatic sample();
        wr_t w;
        @(negedge clk);
        chk("wr_req", wr_req, sb.size() > 0);
        if (sb.size() > 0) begin
            w = sb.pop_front();
            if (wr_req) begin
                chk("wr_add", wr_add, w.a);
                chk("wr_data", wr_data, w.d);
            end
        end
        chk("ready_onehot", $onehot0(m_ready), 1);
        acc = m_valid & m_ready;
        for (int i = 0; i < N; i++) if (acc[i]) sb.push_back({m_add[i], m_data[i]});
        if (busy && !busy_p) begin
            glog.push_back(int'(grant_id));
            gbeats.push_back(0);
        end
        if (acc != 0 && gbeats.size() > 0) gbeats[gbeats.size() - 1]++;
        busy_p = busy;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        acc = '0;
    endtask

    task automatic cyc();
        drive();
        sample();
        adv();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (pending() > 0 && n < max) begin
            cyc();
            n++;
        end
        chk("drain_in_time", pending(), 0);
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        sb.delete();
        glog.delete();
        gbeats.delete();
        busy_p = 1'b0;
        hold = '0;
        acc = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_allow = 1'b0;
        m_valid = '0;
        m_last = '0;
        clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_grants(input int n, input int g[8], input int b[8]);
        chk("grant_count", glog.size(), n);
        for (int i = 0; i < n && i < glog.size(); i++) begin
            chk($sformatf("grant%0d_id", i), glog[i], g[i]);
            chk($sformatf("grant%0d_beats", i), gbeats[i], b[i]);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 2'd0, 4'h1, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b1};
        tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 2'd1, 4'h2, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd1, 4'h0, 1'b1};
        tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b1, 2'd2, 4'h4, 1'b0};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd2, 4'h0, 1'b1};
        tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 2'd3, 4'h8, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd3, 4'h0, 1'b1};
        tbl[11] = '{1'b1, 4'hF, 4'hF, 1'b1, 2'd0, 4'h1, 1'b0};
        tbl[12] = '{1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b1};
        for (int i = 0; i < N; i++) begin
            m_add[i]  = '0;
            m_data[i] = '0;
        end

        // Reset state with requests pending and the write window open
        m_valid = '1;
        wr_allow = 1'b1;
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_add", wr_add, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_grant_id", grant_id, 0);

        // Vector table: no grant while closed, then round-robin rotation with one IDLE gap
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_add[i]  = AW'(16'h1000 + i);
            m_data[i] = 12'(12'h100 + i);
        end
        for (int r = 0; r < 13; r++) begin
            wr_allow = tbl[r].wa;
            m_valid  = tbl[r].v;
            m_last   = tbl[r].l;
            sample();
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].b);
            chk($sformatf("tbl%0d_grant", r), grant_id, tbl[r].g);
            chk($sformatf("tbl%0d_ready", r), m_ready, tbl[r].r);
            chk($sformatf("tbl%0d_wr_req", r), wr_req, tbl[r].w);
            adv();
        end
        chk_grants(5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0, 0, 0});

        // Three-beat burst from master 1, then rr pointer must sit at 2
        do_reset();
        wr_allow = 1'b1;
        load(1, 16'h0010, 12'hABC, 0, 3, 1);
        drain(50);
        drive();
        sample();
        chk("busy_fall", busy, 0);
        adv();
        load(0, 16'h0020, 12'h001, 1, 1, 1);
        load(2, 16'h0030, 12'h002, 1, 1, 1);
        load(3, 16'h0040, 12'h003, 1, 1, 1);
        drain(50);
        chk_grants(4, '{1, 2, 3, 0, 0, 0, 0, 0}, '{3, 1, 1, 1, 0, 0, 0, 0});

        // Long stream from master 0 split at MAX_BURST, interleaved with masters 1 and 2
        do_reset();
        wr_allow = 1'b1;
        load(0, 16'h0200, 12'h000, 1, 40, 0);
        load(1, 16'h0310, 12'h111, 1, 2, 2);
        load(2, 16'h0320, 12'h222, 1, 2, 2);
        drain(300);
        chk_grants(7, '{0, 1, 2, 0, 1, 2, 0, 0}, '{16, 1, 1, 16, 1, 1, 8, 0});

        // Write window closes for 5 cycles mid-burst
        do_reset();
        wr_allow = 1'b1;
        load(2, 16'h0400, 12'h040, 1, 6, 1);
        repeat (3) cyc();
        wr_allow = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive();
            sample();
            chk("stall_ready", m_ready, 0);
            if (k > 0) chk("stall_wr_req", wr_req, 0);
            chk("stall_grant", grant_id, 2);
            chk("stall_busy", busy, 1);
            adv();
        end
        wr_allow = 1'b1;
        drain(50);
        chk_grants(1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0});

        // Granted master goes quiet: release after 8 idle cycles, master 1 granted next
        do_reset();
        wr_allow = 1'b1;
        load(0, 16'h0500, 12'h050, 1, 3, 1);
        load(1, 16'h0510, 12'h051, 1, 1, 1);
        repeat (3) cyc();
        hold[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive();
            sample();
            chk($sformatf("idle%0d_busy", k), busy, 1);
            adv();
        end
        drive();
        sample();
        chk("timeout_release", busy, 0);
        adv();
        drive();
        sample();
        chk("next_busy", busy, 1);
        chk("next_grant", grant_id, 1);
        adv();
        hold[0] = 1'b0;
        drain(50);
        chk_grants(3, '{0, 1, 0, 0, 0, 0, 0, 0}, '{2, 1, 1, 0, 0, 0, 0, 0});

        // Reset during the beat-2 acceptance cycle of a burst from master 3
        do_reset();
        wr_allow = 1'b1;
        load(1, 16'h0600, 12'h061, 1, 1, 1);
        load(3, 16'h0700, 12'h073, 1, 4, 1);
        repeat (4) cyc();
        drive();
        reset = 1'b1;
        sb.delete();
        sample();
        chk("midrst_wr_add", wr_add, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", m_ready, 0);
        chk("midrst_grant", grant_id, 0);
        adv();
        reset = 1'b0;
        clear();
        load(3, 16'h0700, 12'h073, 1, 2, 1);
        load(1, 16'h0800, 12'h081, 1, 1, 1);
        drain(50);
        chk_grants(2, '{1, 3, 0, 0, 0, 0, 0, 0}, '{1, 2, 0, 0, 0, 0, 0, 0});

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
